// File: rtl/core_operand_fetch.sv
// Operand fetch: register-file read, pending-write scoreboard, writeback bypass and a one-deep operand slot.
// Optional macro OPFETCH_STALL_CNT_EN adds stall_cnt_out, a saturating count of hazard stall cycles.
module core_operand_fetch #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_in,
    output logic              req_ready_out,
    input  logic [ADDR_W-1:0] rs1_addr_in,
    input  logic [ADDR_W-1:0] rs2_addr_in,
    input  logic [ADDR_W-1:0] rd_addr_in,
    input  logic              rd_pending_in,
    output logic [ADDR_W-1:0] rf_read_addr1_out,
    output logic [ADDR_W-1:0] rf_read_addr2_out,
    input  logic [DATA_W-1:0] rf_read_data1_in,
    input  logic [DATA_W-1:0] rf_read_data2_in,
    input  logic              wb_we_in,
    input  logic [ADDR_W-1:0] wb_addr_in,
    input  logic [DATA_W-1:0] wb_data_in,
    input  logic              flush_in,
    output logic              op_valid_out,
    input  logic              op_ready_in,
    output logic [DATA_W-1:0] op1_data_out,
    output logic [DATA_W-1:0] op2_data_out,
    output logic [ADDR_W-1:0] op_rd_out,
    output logic              op_rd_pending_out
`ifdef OPFETCH_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt_out
`endif
);

    // Handshakes: a beat moves when valid and ready are both high at a rising clk edge;
    // valid never waits on ready, and held data stays stable until it moves.
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [NREGS-1:0]  sb_q, sb_d;
    logic              wbhit1, wbhit2, hazard1, hazard2, hazard;
    logic              accept, transfer;
    logic [DATA_W-1:0] op1_d, op2_d;

    assign rf_read_addr1_out = rs1_addr_in;
    assign rf_read_addr2_out = rs2_addr_in;

    assign wbhit1  = wb_we_in && (wb_addr_in == rs1_addr_in) && (rs1_addr_in != '0);
    assign wbhit2  = wb_we_in && (wb_addr_in == rs2_addr_in) && (rs2_addr_in != '0);
    assign hazard1 = (rs1_addr_in != '0) && sb_q[rs1_addr_in] && !wbhit1;
    assign hazard2 = (rs2_addr_in != '0) && sb_q[rs2_addr_in] && !wbhit2;
    assign hazard  = req_valid_in && (hazard1 || hazard2);

    assign op_valid_out  = (state_q == FULL);
    assign transfer      = op_valid_out && op_ready_in;
    assign req_ready_out = !hazard && !flush_in && ((state_q == EMPTY) || op_ready_in);
    assign accept        = req_valid_in && req_ready_out;

    assign op1_d = (rs1_addr_in == '0) ? '0 : (wbhit1 ? wb_data_in : rf_read_data1_in);
    assign op2_d = (rs2_addr_in == '0) ? '0 : (wbhit2 ? wb_data_in : rf_read_data2_in);

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (accept) state_d = FULL;
            FULL: begin
                if (flush_in)                 state_d = EMPTY;
                else if (transfer && !accept) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    // Set wins over clear: a new pending write to rd outlives an older writeback to it.
    always_comb begin
        sb_d = sb_q;
        if (wb_we_in && (wb_addr_in != '0))
            sb_d[wb_addr_in] = 1'b0;
        if (flush_in && op_valid_out && op_rd_pending_out && !op_ready_in)
            sb_d[op_rd_out] = 1'b0;
        if (accept && rd_pending_in && (rd_addr_in != '0))
            sb_d[rd_addr_in] = 1'b1;
        sb_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= EMPTY;
            sb_q              <= '0;
            op1_data_out      <= '0;
            op2_data_out      <= '0;
            op_rd_out         <= '0;
            op_rd_pending_out <= 1'b0;
        end else begin
            state_q <= state_d;
            sb_q    <= sb_d;
            if (accept) begin
                op1_data_out      <= op1_d;
                op2_data_out      <= op2_d;
                op_rd_out         <= rd_addr_in;
                op_rd_pending_out <= rd_pending_in && (rd_addr_in != '0);
            end
        end
    end

`ifdef OPFETCH_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt_out <= '0;
        else if (hazard && !flush_in && (stall_cnt_out != 32'hFFFF_FFFF))
            stall_cnt_out <= stall_cnt_out + 32'd1;
    end
`endif

endmodule

// File: tb/tb_core_operand_fetch.sv
// Directed bench for core_operand_fetch: hand-computed operands, stalls, bypass, hold, flush and reset.
module tb_core_operand_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_in, req_ready_out;
    logic [4:0]  rs1_addr_in, rs2_addr_in, rd_addr_in;
    logic        rd_pending_in;
    logic [4:0]  rf_read_addr1_out, rf_read_addr2_out;
    logic [31:0] rf_read_data1_in, rf_read_data2_in;
    logic        wb_we_in;
    logic [4:0]  wb_addr_in;
    logic [31:0] wb_data_in;
    logic        flush_in;
    logic        op_valid_out, op_ready_in;
    logic [31:0] op1_data_out, op2_data_out;
    logic [4:0]  op_rd_out;
    logic        op_rd_pending_out;
`ifdef OPFETCH_STALL_CNT_EN
    logic [31:0] stall_cnt_out;
`endif

    int checks   = 0;
    int failures = 0;

    core_operand_fetch dut (
        .clk(clk), .rst(rst),
        .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
        .rs1_addr_in(rs1_addr_in), .rs2_addr_in(rs2_addr_in),
        .rd_addr_in(rd_addr_in), .rd_pending_in(rd_pending_in),
        .rf_read_addr1_out(rf_read_addr1_out), .rf_read_addr2_out(rf_read_addr2_out),
        .rf_read_data1_in(rf_read_data1_in), .rf_read_data2_in(rf_read_data2_in),
        .wb_we_in(wb_we_in), .wb_addr_in(wb_addr_in), .wb_data_in(wb_data_in),
        .flush_in(flush_in),
        .op_valid_out(op_valid_out), .op_ready_in(op_ready_in),
        .op1_data_out(op1_data_out), .op2_data_out(op2_data_out),
        .op_rd_out(op_rd_out), .op_rd_pending_out(op_rd_pending_out)
`ifdef OPFETCH_STALL_CNT_EN
        , .stall_cnt_out(stall_cnt_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid_in     = 1'b0;
        rs1_addr_in      = '0;
        rs2_addr_in      = '0;
        rd_addr_in       = '0;
        rd_pending_in    = 1'b0;
        rf_read_data1_in = '0;
        rf_read_data2_in = '0;
        wb_we_in         = 1'b0;
        wb_addr_in       = '0;
        wb_data_in       = '0;
        flush_in         = 1'b0;
        op_ready_in      = 1'b1;
    endtask

    task automatic req(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic pend, input logic [31:0] d1, input logic [31:0] d2);
        req_valid_in     = 1'b1;
        rs1_addr_in      = rs1;
        rs2_addr_in      = rs2;
        rd_addr_in       = rd;
        rd_pending_in    = pend;
        rf_read_data1_in = d1;
        rf_read_data2_in = d2;
    endtask

    task automatic wb(input logic we, input logic [4:0] a, input logic [31:0] d);
        wb_we_in   = we;
        wb_addr_in = a;
        wb_data_in = d;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) step();
        rst = 1'b0;
        #1;
        check_eq("rst_valid", op_valid_out, 0);
        check_eq("rst_op1", op1_data_out, 0);
        check_eq("rst_op2", op2_data_out, 0);
        check_eq("rst_rd", op_rd_out, 0);
        check_eq("rst_rd_pend", op_rd_pending_out, 0);
        check_eq("rst_ready", req_ready_out, 1);

        // basic read
        req(5'd1, 5'd2, 5'd0, 1'b0, 32'h11, 32'h22);
        #1;
        check_eq("basic_ready", req_ready_out, 1);
        check_eq("raddr1", rf_read_addr1_out, 1);
        check_eq("raddr2", rf_read_addr2_out, 2);
        step();
        check_eq("basic_valid", op_valid_out, 1);
        check_eq("basic_op1", op1_data_out, 32'h11);
        check_eq("basic_op2", op2_data_out, 32'h22);

        // rd=5 pending, then dependent read stalls until writeback bypasses it
        req(5'd0, 5'd0, 5'd5, 1'b1, 32'h0, 32'h0);
        #1;
        check_eq("pend5_ready", req_ready_out, 1);
        step();
        check_eq("pend5_rd", op_rd_out, 5);
        check_eq("pend5_flag", op_rd_pending_out, 1);
        req(5'd5, 5'd0, 5'd0, 1'b0, 32'h1234, 32'h0);
        #1;
        check_eq("stall_rs1", req_ready_out, 0);
        wb(1'b1, 5'd5, 32'hABCD);
        #1;
        check_eq("bypass_ready", req_ready_out, 1);
        step();
        check_eq("bypass_op1", op1_data_out, 32'hABCD);
        wb(1'b0, 5'd0, 32'h0);
        req(5'd5, 5'd0, 5'd0, 1'b0, 32'h55, 32'h0);
        #1;
        check_eq("sb5_cleared", req_ready_out, 1);
        step();
        check_eq("rf5_op1", op1_data_out, 32'h55);

        // x0 reads as zero, never pending, never bypassed
        req(5'd0, 5'd0, 5'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        #1;
        check_eq("x0_ready", req_ready_out, 1);
        step();
        check_eq("x0_op1", op1_data_out, 0);
        check_eq("x0_op2", op2_data_out, 0);
        check_eq("x0_rd_pend", op_rd_pending_out, 0);
        req(5'd0, 5'd3, 5'd0, 1'b0, 32'hFFFF_FFFF, 32'h33);
        wb(1'b1, 5'd0, 32'hDEAD);
        #1;
        check_eq("x0_nostall", req_ready_out, 1);
        step();
        check_eq("x0_nobyp_op1", op1_data_out, 0);
        check_eq("x0_op2_rf", op2_data_out, 32'h33);

        // hold while execute is not ready, then back-to-back transfer + accept
        wb(1'b0, 5'd0, 32'h0);
        req(5'd1, 5'd2, 5'd0, 1'b0, 32'h66, 32'h77);
        op_ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("hold_ready", req_ready_out, 0);
            step();
            check_eq("hold_valid", op_valid_out, 1);
            check_eq("hold_op1", op1_data_out, 0);
            check_eq("hold_op2", op2_data_out, 32'h33);
        end
        op_ready_in = 1'b1;
        #1;
        check_eq("b2b_ready", req_ready_out, 1);
        step();
        check_eq("b2b_valid", op_valid_out, 1);
        check_eq("b2b_op1", op1_data_out, 32'h66);
        check_eq("b2b_op2", op2_data_out, 32'h77);

        // flush of a held pending rd=7 releases its scoreboard bit
        req(5'd0, 5'd0, 5'd7, 1'b1, 32'h0, 32'h0);
        step();
        check_eq("pend7_rd", op_rd_out, 7);
        op_ready_in = 1'b0;
        flush_in    = 1'b1;
        req(5'd7, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0);
        #1;
        check_eq("flush_ready", req_ready_out, 0);
        step();
        check_eq("flush_valid", op_valid_out, 0);
        flush_in    = 1'b0;
        op_ready_in = 1'b1;
        req(5'd7, 5'd0, 5'd0, 1'b0, 32'h70, 32'h0);
        #1;
        check_eq("sb7_cleared", req_ready_out, 1);
        step();
        check_eq("after_flush_op1", op1_data_out, 32'h70);

        // set beats same-cycle clear; then a 4-cycle stall
        req(5'd0, 5'd0, 5'd3, 1'b1, 32'h0, 32'h0);
        wb(1'b1, 5'd3, 32'h99);
        step();
        wb(1'b0, 5'd0, 32'h0);
        req(5'd3, 5'd0, 5'd0, 1'b0, 32'h3, 32'h0);
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("sb3_stall", req_ready_out, 0);
            step();
        end
        check_eq("stall_empty", op_valid_out, 0);
`ifdef OPFETCH_STALL_CNT_EN
        check_eq("stall_cnt", stall_cnt_out, 4);
`endif
        wb(1'b1, 5'd3, 32'hC3C3);
        #1;
        check_eq("sb3_bypass_ready", req_ready_out, 1);
        step();
        check_eq("sb3_bypass_op1", op1_data_out, 32'hC3C3);

        // reset mid-operation clears held slot and scoreboard
        wb(1'b0, 5'd0, 32'h0);
        req(5'd0, 5'd0, 5'd9, 1'b1, 32'h0, 32'h0);
        step();
        check_eq("pend9_valid", op_valid_out, 1);
        rst = 1'b1;
        idle();
        step();
        rst = 1'b0;
        check_eq("rst2_valid", op_valid_out, 0);
        check_eq("rst2_rd", op_rd_out, 0);
        req(5'd9, 5'd0, 5'd0, 1'b0, 32'h90, 32'h0);
        #1;
        check_eq("rst2_sb9_clear", req_ready_out, 1);
        step();
        check_eq("rst2_op1", op1_data_out, 32'h90);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
